// File: rtl/serial_operand_serializer.sv
// Parallel-to-serial operand front end: streams (a_in, b_in) LSB-first as bit pairs. Optional SERIALIZER_SKID_EN.
// Latency: bit 0 appears the cycle after the accept edge; a word of L bits occupies L output cycles.
// Backpressure: none downstream; in_rdy low while busy (with SERIALIZER_SKID_EN, low only while the holding slot is full).
module serial_operand_serializer #(
    parameter int WIDTH = 8,
    parameter int LENW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_vld,
    output logic            in_rdy,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [LENW-1:0] in_len,
    input  logic            abort,
    output logic            vld,
    output logic            a,
    output logic            b,
    output logic            last
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [LENW-1:0]  cnt, len_m1;

    logic             accept, free_slot, st_go;
    logic [WIDTH-1:0] st_a, st_b;
    logic [LENW-1:0]  st_lm1;

    // Out-of-range lengths (0 or above WIDTH) mean a full-width word.
    function automatic logic [LENW-1:0] len_m1_of(input logic [LENW-1:0] l);
        if (l == '0 || l > LENW'(WIDTH))
            return LENW'(WIDTH - 1);
        return l - LENW'(1);
    endfunction

    assign accept    = in_vld && in_rdy;
    assign free_slot = (state == IDLE) || last;

`ifdef SERIALIZER_SKID_EN
    logic             hold_full, hold_full_nxt, load_hold;
    logic [WIDTH-1:0] hold_a, hold_b;
    logic [LENW-1:0]  hold_lm1;

    // A held word has priority for the next free output slot; a fresh word then waits in the hold.
    always_comb begin
        st_go     = 1'b0;
        st_a      = a_in;
        st_b      = b_in;
        st_lm1    = len_m1_of(in_len);
        load_hold = 1'b0;
        if (free_slot && hold_full) begin
            st_go     = 1'b1;
            st_a      = hold_a;
            st_b      = hold_b;
            st_lm1    = hold_lm1;
            load_hold = accept;
        end else if (free_slot && accept) begin
            st_go = 1'b1;
        end else begin
            load_hold = accept;
        end
        hold_full_nxt = (hold_full && !free_slot) || load_hold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_a    <= '0;
            hold_b    <= '0;
            hold_lm1  <= '0;
            in_rdy    <= 1'b0;
        end else if (abort) begin
            hold_full <= 1'b0;
            in_rdy    <= 1'b1;
        end else begin
            hold_full <= hold_full_nxt;
            in_rdy    <= !hold_full_nxt;
            if (load_hold) begin
                hold_a   <= a_in;
                hold_b   <= b_in;
                hold_lm1 <= len_m1_of(in_len);
            end
        end
    end
`else
    always_comb begin
        st_go  = accept;
        st_a   = a_in;
        st_b   = b_in;
        st_lm1 = len_m1_of(in_len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            in_rdy <= 1'b0;
        else if (abort)
            in_rdy <= 1'b1;
        else
            in_rdy <= !st_go && free_slot;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            len_m1 <= '0;
            vld    <= 1'b0;
            a      <= 1'b0;
            b      <= 1'b0;
            last   <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            cnt   <= '0;
            vld   <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
            last  <= 1'b0;
        end else if (st_go) begin
            state  <= SHIFT;
            sh_a   <= st_a >> 1;
            sh_b   <= st_b >> 1;
            cnt    <= '0;
            len_m1 <= st_lm1;
            vld    <= 1'b1;
            a      <= st_a[0];
            b      <= st_b[0];
            last   <= (st_lm1 == '0);
        end else if (state == SHIFT && !last) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            cnt  <= cnt + LENW'(1);
            a    <= sh_a[0];
            b    <= sh_b[0];
            last <= (cnt + LENW'(1) == len_m1);
        end else begin
            state <= IDLE;
            cnt   <= '0;
            vld   <= 1'b0;
            a     <= 1'b0;
            b     <= 1'b0;
            last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Testbench for serial_operand_serializer: directed scenarios plus random traffic against a bit-queue reference model.
module tb_serial_operand_serializer;

    typedef struct packed {
        logic a;
        logic b;
        logic l;
    } bit_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_vld = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] a_in = '0;
    logic [7:0] b_in = '0;
    logic [3:0] in_len = '0;
    logic       in_rdy, vld, a, b, last;

    int checks = 0;
    int failures = 0;

    // Reference model: q holds the bits still to be shown, front = bit on the wires now.
    bit_t       q[$];
    bit         held = 0;
    logic [7:0] h_a, h_b;
    int         h_len;
    bit         m_rdy = 0;
    bit         acc_flag = 0;
    logic       o_vld, o_a, o_b, o_last;

    serial_operand_serializer #(.WIDTH(8), .LENW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .a_in(a_in), .b_in(b_in), .in_len(in_len), .abort(abort),
        .vld(vld), .a(a), .b(b), .last(last)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int eff_len(input logic [3:0] l);
        return (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    endfunction

    task automatic push_word(input logic [7:0] wa, input logic [7:0] wb, input int len);
        bit_t e;
        for (int k = 0; k < len; k++) begin
            e.a = wa[k];
            e.b = wb[k];
            e.l = (k == len - 1);
            q.push_back(e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        held = 0;
        m_rdy = 0;
    endtask

    task automatic model_edge();
        bit acc;
        acc_flag = 0;
        if (!rst_n) return;
        acc = in_vld && m_rdy;
        acc_flag = acc && !abort;
        if (abort) begin
            q.delete();
            held = 0;
            m_rdy = 1;
            return;
        end
        if (q.size() > 0) void'(q.pop_front());
`ifdef SERIALIZER_SKID_EN
        if (q.size() == 0 && held) begin
            push_word(h_a, h_b, h_len);
            held = 0;
        end
        if (acc) begin
            if (q.size() == 0) push_word(a_in, b_in, eff_len(in_len));
            else begin
                held = 1; h_a = a_in; h_b = b_in; h_len = eff_len(in_len);
            end
        end
        m_rdy = !held;
`else
        if (acc) push_word(a_in, b_in, eff_len(in_len));
        m_rdy = (q.size() == 0);
`endif
    endtask

    task automatic check_outputs();
        bit_t e;
        logic ev;
        ev = (q.size() > 0);
        e  = ev ? q[0] : '0;
        chk1("vld", vld, ev);
        chk1("a", a, e.a);
        chk1("b", b, e.b);
        chk1("last", last, e.l);
        chk1("in_rdy", in_rdy, m_rdy);
        o_vld = vld; o_a = a; o_b = b; o_last = last;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic send_word(input logic [7:0] wa, input logic [7:0] wb, input logic [3:0] wl);
        bit got = 0;
        a_in = wa; b_in = wb; in_len = wl; in_vld = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            step();
            got = acc_flag;
        end
        in_vld = 1'b0;
        if (!got) chkv("accept_timeout", 32'(got), 32'd1);
    endtask

    logic [7:0]  va, vb, lm;
    logic [16:0] vmask, lmask;
    bit          saw_last, got2;

    initial begin
        // 1: reset
        model_reset();
        #2;
        chk1("rst_vld", vld, 1'b0);
        chk1("rst_rdy", in_rdy, 1'b0);
        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk1("rdy_after_rst", in_rdy, 1'b1);

        // 2: full-width word via in_len=0
        send_word(8'hA5, 8'h3C, 4'd0);
        va = '0; vb = '0; lm = '0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            va[i] = o_a; vb[i] = o_b; lm[i] = o_last;
        end
        chkv("w8_a", 32'(va), 32'hA5);
        chkv("w8_b", 32'(vb), 32'h3C);
        chkv("w8_last", 32'(lm), 32'h80);
        step();

        // 3: short word
        send_word(8'hFF, 8'h01, 4'd3);
        va = '0; vb = '0; lm = '0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            va[i] = o_a; vb[i] = o_b; lm[i] = o_last;
        end
        chkv("w3_a", 32'(va), 32'h7);
        chkv("w3_b", 32'(vb), 32'h1);
        chkv("w3_last", 32'(lm), 32'h4);
        step();
        chk1("w3_rdy_after", in_rdy, 1'b1);

        // length 1 and an out-of-range length
        send_word(8'h01, 8'h00, 4'd1);
        chk1("w1_last", o_last, 1'b1);
        step();
        send_word(8'h5A, 8'hC3, 4'd12);
        repeat (8) step();

        // 4: abort at bit 4
        send_word(8'h5A, 8'h96, 4'd0);
        saw_last = o_last;
        repeat (4) begin step(); saw_last |= o_last; end
        abort = 1'b1; step(); abort = 1'b0;
        chk1("abort_vld", o_vld, 1'b0);
        chk1("abort_no_last", saw_last, 1'b0);
        send_word(8'h81, 8'h7E, 4'd0);
        chk1("post_abort_a0", o_a, 1'b1);
        chk1("post_abort_b0", o_b, 1'b0);
        repeat (8) step();

        // abort coinciding with an accept drops the word
        a_in = 8'hFF; b_in = 8'hFF; in_vld = 1'b1; abort = 1'b1;
        step();
        in_vld = 1'b0; abort = 1'b0;
        chk1("abort_accept_vld", o_vld, 1'b0);
        step();

        // 5: back-to-back with in_vld held
        send_word(8'h0F, 8'h0F, 4'd0);
        a_in = 8'hF0; b_in = 8'hF0; in_vld = 1'b1;
        vmask = '0; lmask = '0; got2 = 0;
        vmask[0] = o_vld; lmask[0] = o_last;
        for (int i = 1; i < 17; i++) begin
            step();
            if (acc_flag) begin in_vld = 1'b0; got2 = 1; end
            vmask[i] = o_vld; lmask[i] = o_last;
        end
        in_vld = 1'b0;
        chk1("b2b_second_accepted", got2, 1'b1);
`ifdef SERIALIZER_SKID_EN
        chkv("b2b_vld", 32'(vmask), 32'h0FFFF);
        chkv("b2b_last", 32'(lmask), 32'h08080);
`else
        chkv("b2b_vld", 32'(vmask), 32'h1FEFF);
        chkv("b2b_last", 32'(lmask), 32'h10080);
`endif
        repeat (3) step();

        // 6: reset pulse at bit 5
        send_word(8'hFF, 8'hAA, 4'd0);
        repeat (5) step();
        chk1("pre_rst_vld", o_vld, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk1("arst_vld", vld, 1'b0);
        chk1("arst_a", a, 1'b0);
        chk1("arst_b", b, 1'b0);
        chk1("arst_last", last, 1'b0);
        step(); step();
        #2 rst_n = 1'b1;
        repeat (3) step();

        // random traffic, including abort and payload churn while busy
        for (int c = 0; c < 600; c++) begin
            in_vld = ($urandom_range(0, 2) != 0);
            a_in   = 8'($urandom);
            b_in   = 8'($urandom);
            in_len = 4'($urandom_range(0, 15));
            abort  = ($urandom_range(0, 40) == 0);
            step();
        end
        in_vld = 1'b0; abort = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
